psdu_extractor: RTL and testbench

- Receive-chain stage directly downstream of the descrambler.
- Takes the descrambled serial DATA-field bit stream, checks and strips the 16-bit SERVICE field, and packs the PSDU LSB-first into bytes for the MAC.
- Stops after the LENGTH bytes given by the SIGNAL field; the tail and pad bits that follow are discarded.

---
 rtl/psdu_extractor.sv | 110 +++++++++++
 tb/tb_psdu_extractor.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/psdu_extractor.sv
// Strips and checks the 16-bit SERVICE field from the descrambled DATA stream,
// then packs LENGTH PSDU bytes LSB-first for the MAC and drops tail/pad bits.
module psdu_extractor #(
    parameter int unsigned LENGTH_WIDTH        = 12,
    parameter int unsigned SERVICE_BITS        = 16,
    parameter int unsigned SCRAMBLER_INIT_BITS = 7
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    Start,
    input  logic [LENGTH_WIDTH-1:0] Length,
    input  logic                    Input,
    input  logic                    InputValid,
    output logic [7:0]              Output,
    output logic                    OutputValid,
    output logic                    Done,
    output logic                    ServiceError,
    output logic                    Busy
);

    localparam int unsigned BCW = $clog2(SERVICE_BITS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVICE = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    state_t                  state;
    logic [BCW-1:0]          bit_cnt;
    logic [2:0]              bit_in_byte;
    logic [LENGTH_WIDTH-1:0] byte_cnt;
    logic [LENGTH_WIDTH-1:0] len_q;
    logic [7:0]              shreg;
    logic [7:0]              shreg_nxt;

    // New bit enters at the MSB so the first bit received ends at bit 0.
    assign shreg_nxt = {Input, shreg[7:1]};

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            bit_in_byte  <= '0;
            byte_cnt     <= '0;
            len_q        <= '0;
            shreg        <= '0;
            Output       <= '0;
            OutputValid  <= 1'b0;
            Done         <= 1'b0;
            ServiceError <= 1'b0;
            Busy         <= 1'b0;
        end else begin
            OutputValid <= 1'b0;
            Done        <= 1'b0;
            if (Start) begin
                // Start wins in every state; the bit in this cycle is not consumed.
                state        <= SERVICE;
                len_q        <= Length;
                bit_cnt      <= '0;
                bit_in_byte  <= '0;
                byte_cnt     <= '0;
                shreg        <= '0;
                ServiceError <= 1'b0;
                Busy         <= 1'b1;
            end else begin
                case (state)
                    SERVICE: begin
                        if (InputValid) begin
                            bit_cnt <= bit_cnt + BCW'(1);
                            if (bit_cnt < BCW'(SCRAMBLER_INIT_BITS) && Input) begin
                                ServiceError <= 1'b1;
                            end
                            if (bit_cnt == BCW'(SERVICE_BITS - 1)) begin
                                if (len_q == '0) begin
                                    state <= IDLE;
                                    Done  <= 1'b1;
                                    Busy  <= 1'b0;
                                end else begin
                                    state <= PAYLOAD;
                                end
                            end
                        end
                    end
                    PAYLOAD: begin
                        if (InputValid) begin
                            shreg       <= shreg_nxt;
                            bit_in_byte <= bit_in_byte + 3'd1;
                            if (bit_in_byte == 3'd7) begin
                                Output      <= shreg_nxt;
                                OutputValid <= 1'b1;
                                byte_cnt    <= byte_cnt + LENGTH_WIDTH'(1);
                                // Compare against len-1 so a 4095-byte frame never wraps.
                                if (byte_cnt == len_q - LENGTH_WIDTH'(1)) begin
                                    state <= IDLE;
                                    Done  <= 1'b1;
                                    Busy  <= 1'b0;
                                end
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_psdu_extractor.sv
// Scoreboard bench for psdu_extractor: expected strobes are queued as frames
// are driven and matched by a negedge monitor.
module tb_psdu_extractor;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [11:0] Length = '0;
    logic        Input = 1'b0;
    logic        InputValid = 1'b0;
    logic [7:0]  Output;
    logic        OutputValid;
    logic        Done;
    logic        ServiceError;
    logic        Busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       is_byte;
        logic [7:0] data;
        logic       done;
    } exp_t;

    exp_t sb[$];

    psdu_extractor dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Start       (Start),
        .Length      (Length),
        .Input       (Input),
        .InputValid  (InputValid),
        .Output      (Output),
        .OutputValid (OutputValid),
        .Done        (Done),
        .ServiceError(ServiceError),
        .Busy        (Busy)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Every OutputValid/Done strobe must match the head of the scoreboard.
    always @(negedge Clock) begin
        if (Reset === 1'b0 && (OutputValid === 1'b1 || Done === 1'b1)) begin
            if (sb.size() == 0) begin
                chk("spurious_strobe", {30'd0, OutputValid, Done}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ov_flag", 32'(OutputValid), 32'(e.is_byte));
                if (e.is_byte) chk("ov_data", 32'(Output), 32'(e.data));
                chk("done", 32'(Done), 32'(e.done));
            end
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic push(input logic is_byte, input logic [7:0] data, input logic done);
        exp_t e;
        e.is_byte = is_byte;
        e.data    = data;
        e.done    = done;
        sb.push_back(e);
    endtask

    task automatic start_frame(input logic [11:0] len);
        Start      = 1'b1;
        Length     = len;
        InputValid = 1'b1;
        Input      = 1'b1;
        tick();
        Start      = 1'b0;
        InputValid = 1'b0;
        Input      = 1'b0;
    endtask

    task automatic send(input logic b, input int gap);
        Input      = b;
        InputValid = 1'b1;
        tick();
        InputValid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_service(input logic [15:0] bits, input int gap);
        for (int i = 0; i < 16; i++) send(bits[i], gap);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        for (int i = 0; i < 8; i++) send(b[i], gap);
    endtask

    initial begin
        logic [15:0] svc;

        // Reset
        tick();
        tick();
        chk("rst_output", 32'(Output), 32'h00);
        chk("rst_ov", 32'(OutputValid), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_serr", 32'(ServiceError), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        Reset = 1'b0;
        tick();

        // Basic two-byte frame, continuous InputValid
        start_frame(12'd2);
        chk("busy_after_start", 32'(Busy), 32'd1);
        push(1'b1, 8'hA5, 1'b0);
        push(1'b1, 8'h3C, 1'b1);
        send_service(16'h0000, 0);
        send_byte(8'hA5, 0);
        send_byte(8'h3C, 0);
        chk("f1_serr", 32'(ServiceError), 32'd0);
        chk("f1_busy_end", 32'(Busy), 32'd0);
        repeat (4) tick();

        // SERVICE bit 3 set -> sticky error
        start_frame(12'd2);
        svc = 16'h0008;
        push(1'b1, 8'hA5, 1'b0);
        push(1'b1, 8'h3C, 1'b1);
        for (int i = 0; i < 16; i++) begin
            send(svc[i], 0);
            if (i == 2) chk("serr_before", 32'(ServiceError), 32'd0);
            if (i == 3) chk("serr_set", 32'(ServiceError), 32'd1);
        end
        send_byte(8'hA5, 0);
        send_byte(8'h3C, 0);
        repeat (3) tick();
        chk("serr_sticky", 32'(ServiceError), 32'd1);

        // SERVICE bit 10 set -> not a scrambler-init bit
        start_frame(12'd2);
        chk("serr_clr_start", 32'(ServiceError), 32'd0);
        push(1'b1, 8'hA5, 1'b0);
        push(1'b1, 8'h3C, 1'b1);
        send_service(16'h0400, 0);
        send_byte(8'hA5, 0);
        send_byte(8'h3C, 0);
        chk("serr_bit10", 32'(ServiceError), 32'd0);
        repeat (3) tick();

        // Length = 0: Done only, one cycle after the 16th bit
        start_frame(12'd0);
        push(1'b0, 8'h00, 1'b1);
        send_service(16'h0000, 0);
        chk("len0_busy", 32'(Busy), 32'd0);
        repeat (5) tick();

        // Length = 1, gapped input, followed by tail/pad bits
        start_frame(12'd1);
        push(1'b1, 8'h96, 1'b1);
        send_service(16'h0000, 1);
        send_byte(8'h96, 1);
        for (int i = 0; i < 30; i++) send(1'($urandom_range(0, 1)), 0);
        chk("len1_idle", 32'(Busy), 32'd0);
        repeat (3) tick();

        // Abort mid-PAYLOAD after 11 bits; first full byte is legitimately delivered
        start_frame(12'd3);
        push(1'b1, 8'h5A, 1'b0);
        send_service(16'h0000, 0);
        send_byte(8'h5A, 0);
        send(1'b1, 0);
        send(1'b0, 0);
        send(1'b1, 0);
        start_frame(12'd1);
        chk("abort_busy", 32'(Busy), 32'd1);
        push(1'b1, 8'hFF, 1'b1);
        send_service(16'h0000, 0);
        send_byte(8'hFF, 0);
        repeat (3) tick();

        // Reset during SERVICE
        start_frame(12'd1);
        send_service(16'h0002, 0);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("mid_rst_busy", 32'(Busy), 32'd0);
        chk("mid_rst_ov", 32'(OutputValid), 32'd0);
        chk("mid_rst_serr", 32'(ServiceError), 32'd0);
        chk("mid_rst_out", 32'(Output), 32'h00);
        for (int i = 0; i < 24; i++) send(1'b1, 0);
        chk("post_rst_busy", 32'(Busy), 32'd0);
        repeat (3) tick();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
